// File: rtl/mem_align_unit_pkg.sv
// Shared types for the load/store alignment path.
package mem_align_unit_pkg;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } mem_size_t;

endpackage

// File: rtl/mem_align_unit_byte_lane_steer.sv
// Combinational lane steering: byte select/extend and split merge on loads,
// replicate/rotate and per-lane enables on stores.
module byte_lane_steer
    import mem_align_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANES  = WIDTH / 8,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic              phase,
    input  logic [LANE_W-1:0] lane,
    input  mem_size_t         size,
    input  logic              is_write,
    input  logic              is_signed,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  rdata_lo,
    input  logic [WIDTH-1:0]  rdata_hi,
    output logic [WIDTH-1:0]  wdata_out,
    output logic [LANES-1:0]  byte_enable,
    output logic [WIDTH-1:0]  rdata_out
);

    logic [LANE_W+2:0] shamt;
    logic [WIDTH-1:0]  rotated;
    logic [WIDTH-1:0]  split_low;
    logic [7:0]        sel_byte;
    logic [LANES-1:0]  one_hot;
    logic [LANES-1:0]  low_mask;

    assign shamt     = {lane, 3'b000};
    assign rotated   = WIDTH'({wdata, wdata} >> (WIDTH - shamt));
    // Second access holds the high bytes: window the pair {acc2, acc1} at lane k.
    assign split_low = WIDTH'({rdata_hi, rdata_lo} >> shamt);
    assign sel_byte  = 8'(rdata_hi >> shamt);
    assign one_hot   = LANES'(1) << lane;
    assign low_mask  = one_hot - LANES'(1);

    always_comb begin
        wdata_out   = rotated;
        byte_enable = '0;
        rdata_out   = rdata_hi;
        if (size == SIZE_BYTE) begin
            wdata_out = {LANES{wdata[7:0]}};
            rdata_out = is_signed ? {{(WIDTH-8){sel_byte[7]}}, sel_byte}
                                  : {{(WIDTH-8){1'b0}}, sel_byte};
            if (is_write) byte_enable = one_hot;
        end else begin
            if (phase) rdata_out = split_low;
            if (is_write) byte_enable = phase ? low_mask : ~low_mask;
        end
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: accepts one request at a time and issues one or
// two lane-aligned memory transactions, returning the aligned load result.
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int ADDR_W          = 16,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  mem_size_t              req_size,
    input  logic                   req_signed,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [WIDTH-1:0]       req_wdata,
    output logic                   resp_valid,
    output logic [WIDTH-1:0]       resp_rdata,
    output logic                   resp_err,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic [WIDTH/8-1:0]     mem_byte_enable,
    input  logic [WIDTH-1:0]       mem_rdata,
    input  logic                   mem_resp
);

    localparam int LANES  = WIDTH / 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC1,
        ST_ACC2,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic              write_q;
    logic              signed_q;
    logic              split_q;
    mem_size_t         size_q;
    logic [LANE_W-1:0] lane_q;
    logic [WIDTH-1:0]  acc1_q;

    logic              in_idle;
    logic              req_split;
    logic [ADDR_W-1:0] aligned_addr;
    logic [LANE_W-1:0] st_lane;
    mem_size_t         st_size;
    logic              st_write;
    logic              st_signed;
    logic [WIDTH-1:0]  st_wdata;
    logic [LANES-1:0]  st_be;
    logic [WIDTH-1:0]  st_rdata;

    assign in_idle      = (state_q == ST_IDLE);
    assign req_ready    = in_idle;
    assign req_split    = (req_size == SIZE_WORD) && (req_addr[LANE_W-1:0] != '0);
    assign aligned_addr = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

    // While idle the steering works on the live request so strobes can launch at accept.
    assign st_lane   = in_idle ? req_addr[LANE_W-1:0] : lane_q;
    assign st_size   = in_idle ? req_size : size_q;
    assign st_write  = in_idle ? req_write : write_q;
    assign st_signed = in_idle ? req_signed : signed_q;

    byte_lane_steer #(
        .WIDTH (WIDTH)
    ) u_steer (
        .phase       (state_q == ST_ACC2),
        .lane        (st_lane),
        .size        (st_size),
        .is_write    (st_write),
        .is_signed   (st_signed),
        .wdata       (req_wdata),
        .rdata_lo    (acc1_q),
        .rdata_hi    (mem_rdata),
        .wdata_out   (st_wdata),
        .byte_enable (st_be),
        .rdata_out   (st_rdata)
    );

    // Request FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            write_q         <= 1'b0;
            signed_q        <= 1'b0;
            split_q         <= 1'b0;
            size_q          <= SIZE_BYTE;
            lane_q          <= '0;
            acc1_q          <= '0;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        split_q  <= req_split;
                        size_q   <= req_size;
                        lane_q   <= req_addr[LANE_W-1:0];
                        if (req_split && !ALLOW_UNALIGNED) begin
                            state_q    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_q         <= ST_ACC1;
                            mem_read        <= !req_write;
                            mem_write       <= req_write;
                            mem_address     <= aligned_addr;
                            mem_wdata       <= st_wdata;
                            mem_byte_enable <= st_be;
                        end
                    end
                end
                ST_ACC1: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        acc1_q    <= mem_rdata;
                        if (split_q) begin
                            state_q <= ST_ACC2;
                        end else begin
                            state_q    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            if (!write_q) resp_rdata <= st_rdata;
                        end
                    end
                end
                ST_ACC2: begin
                    // First ACC2 cycle is the mandatory strobe gap; mem_resp is ignored there.
                    if (!mem_read && !mem_write) begin
                        mem_read        <= !write_q;
                        mem_write       <= write_q;
                        mem_address     <= mem_address + ADDR_W'(LANES);
                        mem_byte_enable <= st_be;
                    end else if (mem_resp) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        state_q    <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (!write_q) resp_rdata <= st_rdata;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed scoreboard bench for mem_align_unit: expected memory transactions
// and responses are queued at stimulus time and compared as the DUT produces them.
module tb_mem_align_unit;
    import mem_align_unit_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } mem_exp_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid_na = 1'b0;
    logic        req_write = 1'b0;
    mem_size_t   req_size = SIZE_BYTE;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        mem_resp_na = 1'b0;

    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [15:0] resp_rdata, mem_address, mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        req_ready_na, resp_valid_na, resp_err_na, mem_read_na, mem_write_na;
    logic [15:0] resp_rdata_na, mem_address_na, mem_wdata_na;
    logic [1:0]  mem_byte_enable_na;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    mem_align_unit #(.WIDTH(16), .ADDR_W(16), .ALLOW_UNALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_align_unit #(.WIDTH(16), .ADDR_W(16), .ALLOW_UNALIGNED(1'b0)) dut_na (
        .clk(clk), .reset(reset), .req_valid(req_valid_na), .req_ready(req_ready_na),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_na),
        .resp_rdata(resp_rdata_na), .resp_err(resp_err_na), .mem_read(mem_read_na),
        .mem_write(mem_write_na), .mem_address(mem_address_na), .mem_wdata(mem_wdata_na),
        .mem_byte_enable(mem_byte_enable_na), .mem_rdata(mem_rdata), .mem_resp(mem_resp_na)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        mem_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
        mem_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [15:0] rdata, input logic err, input logic [7:0] lat);
        rsp_exp_t r;
        r.rdata = rdata; r.err = err; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    // Latency counts the accept cycle as cycle 1.
    task automatic apply_stimulus(input logic wr, input mem_size_t size, input logic sgn,
                                  input logic [15:0] addr, input logic [15:0] wdata);
        req_write = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        accept_cyc = cyc;
        compare("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic serve_mem(input string tag, input logic [15:0] rdata, input int exp_gap);
        int idle = 0;
        mem_exp_t e;
        while (!(mem_read || mem_write) && idle < 20) begin
            @(negedge clk);
            idle++;
        end
        compare({tag, "_gap"}, idle, exp_gap);
        compare({tag, "_memq"}, mem_q.size() != 0, 1'b1);
        if (mem_q.size() != 0) begin
            e = mem_q.pop_front();
            compare({tag, "_addr"}, mem_address, e.addr);
            compare({tag, "_wr"}, mem_write, e.wr);
            compare({tag, "_rd"}, mem_read, !e.wr);
            compare({tag, "_be"}, mem_byte_enable, e.be);
            if (e.wr) compare({tag, "_wdata"}, mem_wdata, e.wdata);
        end
        mem_rdata = rdata;
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = '0;
        compare({tag, "_drop"}, mem_read || mem_write, 1'b0);
    endtask

    task automatic check_output(input string tag);
        int n = 0;
        rsp_exp_t r;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        compare({tag, "_valid"}, resp_valid, 1'b1);
        compare({tag, "_rspq"}, rsp_q.size() != 0, 1'b1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            compare({tag, "_rdata"}, resp_rdata, r.rdata);
            compare({tag, "_err"}, resp_err, r.err);
            compare({tag, "_lat"}, cyc - accept_cyc + 1, r.lat);
        end
        @(negedge clk);
        compare({tag, "_pulse"}, resp_valid, 1'b0);
        compare({tag, "_ready"}, req_ready, 1'b1);
        compare({tag, "_idle"}, mem_read || mem_write, 1'b0);
    endtask

    initial begin
        rsp_exp_t r;
        repeat (2) @(negedge clk);
        compare("rst_ready", req_ready, 1'b1);
        compare("rst_valid", resp_valid, 1'b0);
        compare("rst_err", resp_err, 1'b0);
        compare("rst_rdata", resp_rdata, 16'h0000);
        compare("rst_strobes", {mem_read, mem_write}, 2'b00);
        compare("rst_be", mem_byte_enable, 2'b00);
        compare("rst_addr", mem_address, 16'h0000);
        compare("rst_wdata", mem_wdata, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] byte loads");
        push_mem(1'b0, 16'h3000, 16'h0000, 2'b00);
        push_rsp(16'hFF80, 1'b0, 8'd3);
        apply_stimulus(1'b0, SIZE_BYTE, 1'b1, 16'h3001, 16'h0000);
        serve_mem("ldb_s", 16'h80A5, 0);
        check_output("ldb_s");

        push_mem(1'b0, 16'h3000, 16'h0000, 2'b00);
        push_rsp(16'h0080, 1'b0, 8'd3);
        apply_stimulus(1'b0, SIZE_BYTE, 1'b0, 16'h3001, 16'h0000);
        serve_mem("ldb_u", 16'h80A5, 0);
        check_output("ldb_u");

        $display("[TB] word loads");
        push_mem(1'b0, 16'h3000, 16'h0000, 2'b00);
        push_rsp(16'h1234, 1'b0, 8'd3);
        apply_stimulus(1'b0, SIZE_WORD, 1'b0, 16'h3000, 16'h0000);
        serve_mem("ldw_al", 16'h1234, 0);
        check_output("ldw_al");

        push_mem(1'b0, 16'h3000, 16'h0000, 2'b00);
        push_mem(1'b0, 16'h3002, 16'h0000, 2'b00);
        push_rsp(16'hCDAB, 1'b0, 8'd5);
        apply_stimulus(1'b0, SIZE_WORD, 1'b0, 16'h3001, 16'h0000);
        serve_mem("ldw_un1", 16'hAB12, 0);
        serve_mem("ldw_un2", 16'h77CD, 1);
        check_output("ldw_un");

        $display("[TB] stores");
        push_mem(1'b1, 16'h4000, 16'hEEEE, 2'b10);
        push_rsp(16'hCDAB, 1'b0, 8'd3);
        apply_stimulus(1'b1, SIZE_BYTE, 1'b0, 16'h4001, 16'h00EE);
        serve_mem("stb", 16'h0000, 0);
        check_output("stb");

        push_mem(1'b1, 16'hFFFE, 16'hEFBE, 2'b10);
        push_mem(1'b1, 16'h0000, 16'hEFBE, 2'b01);
        push_rsp(16'hCDAB, 1'b0, 8'd5);
        apply_stimulus(1'b1, SIZE_WORD, 1'b0, 16'hFFFF, 16'hBEEF);
        serve_mem("stw_un1", 16'h0000, 0);
        serve_mem("stw_un2", 16'h0000, 1);
        check_output("stw_un");

        $display("[TB] reset during second access");
        push_mem(1'b0, 16'h3000, 16'h0000, 2'b00);
        apply_stimulus(1'b0, SIZE_WORD, 1'b0, 16'h3001, 16'h0000);
        serve_mem("rst_acc1", 16'hAB12, 0);
        @(negedge clk);
        compare("rst_acc2_rd", mem_read, 1'b1);
        compare("rst_acc2_addr", mem_address, 16'h3002);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compare("rst_abort_strobes", {mem_read, mem_write}, 2'b00);
        compare("rst_abort_ready", req_ready, 1'b1);
        compare("rst_abort_valid", resp_valid, 1'b0);
        compare("rst_abort_rdata", resp_rdata, 16'h0000);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        compare("stray_valid", resp_valid, 1'b0);
        compare("stray_strobes", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        compare("stray_valid2", resp_valid, 1'b0);
        compare("stray_ready", req_ready, 1'b1);

        $display("[TB] unaligned word with splitting disabled");
        push_rsp(16'h0000, 1'b1, 8'd2);
        req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
        req_addr = 16'h3001; req_valid_na = 1'b1;
        accept_cyc = cyc;
        compare("na_ready", req_ready_na, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid_na = 1'b0;
        compare("na_valid", resp_valid_na, 1'b1);
        compare("na_strobes", {mem_read_na, mem_write_na}, 2'b00);
        compare("na_rspq", rsp_q.size() != 0, 1'b1);
        if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            compare("na_err", resp_err_na, r.err);
            compare("na_rdata", resp_rdata_na, r.rdata);
            compare("na_lat", cyc - accept_cyc + 1, r.lat);
        end
        @(negedge clk);
        compare("na_pulse", resp_valid_na, 1'b0);
        compare("na_strobes2", {mem_read_na, mem_write_na}, 2'b00);
        compare("na_ready2", req_ready_na, 1'b1);

        compare("memq_drained", mem_q.size(), 0);
        compare("rspq_drained", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
Parametrised load/store alignment unit between the datapath and the memory port. It generalises the single-cycle byte mask into a full load/store path with zero/sign-extended byte loads, byte-lane stores with write enables, and an optional split of unaligned word accesses into two memory transactions. It sits between the MDR/MAR datapath logic and the memory interface and uses a valid/ready request handshake and a mem_resp-driven memory handshake.

Parameters:
WIDTH, 16, data word width in bits; multiple of 8, >= 16; LANES = WIDTH/8
ADDR_W, 16, address width in bits
ALLOW_UNALIGNED, 1, 1 = split unaligned word access into two transactions; 0 = reject with resp_err

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_size  in  1  mem_size_t: SIZE_BYTE / SIZE_WORD
req_signed  in  1  byte load sign-extends when 1, zero-extends when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  WIDTH  store data; byte store uses [7:0]
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  WIDTH  load result, held until next accepted request
resp_err  out  1  valid with resp_valid; misaligned word with ALLOW_UNALIGNED=0
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  lane-aligned address (low log2(LANES) bits zero)
mem_wdata  out  WIDTH  memory write data
mem_byte_enable  out  LANES  per-lane write enable
mem_rdata  in  WIDTH  memory read data, valid with mem_resp
mem_resp  in  1  memory transaction complete

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=mem_write=0; mem_byte_enable=0; mem_address=0; mem_wdata=0. Reset in any state aborts at that edge; strobes low the next cycle; no resp_valid generated.
- Request latched on req_valid & req_ready; addr, size, signed, write, wdata captured. k = req_addr mod LANES.
- States: IDLE -> ACC1 on accept (IDLE -> DONE with resp_err=1 if word, k!=0, ALLOW_UNALIGNED=0; no memory access). ACC1 -> ACC2 on mem_resp if split (word, k!=0); else ACC1 -> DONE on mem_resp. ACC2 -> DONE on mem_resp. DONE -> IDLE unconditionally; resp_valid=1 in DONE only.
- Strobes are registered: asserted the cycle after accept; held steady (address, data, enables) until mem_resp; deasserted the cycle after mem_resp. Between ACC1 and ACC2 strobes drop for exactly one cycle.
- mem_resp in IDLE or DONE is ignored.
- Min latency (mem_resp in first strobe cycle): aligned 3 cycles accept-to-resp_valid; split 5.
- ACC1 address = addr with low bits cleared (A0); ACC2 address = A0 + LANES, modulo 2^ADDR_W (wraps 0xFFFE -> 0x0000).
- Byte load: result = lane k of mem_rdata, zero- or sign-extended to WIDTH.
- Word load aligned: result = mem_rdata. Split: little-endian; result bytes 0..LANES-k-1 = ACC1 lanes k..LANES-1; remaining high bytes = ACC2 lanes 0..k-1. ACC1 bytes held in an internal register.
- Byte store: mem_wdata = req_wdata[7:0] replicated to all lanes; mem_byte_enable one-hot at lane k.
- Word store: mem_wdata = req_wdata rotated left by k bytes (both accesses); ACC1 enables lanes >= k; ACC2 enables lanes < k; aligned = all ones.
- Loads drive mem_byte_enable = 0. resp_err forces resp_rdata unchanged.

Decomposition:
- lc3b_types gains mem_size_t enum (SIZE_BYTE, SIZE_WORD); FSM state enum stays local.
- One combinational sub-module: byte_lane_steer (lane select + extend on read; replicate/rotate + enable generation on write, parametrised by WIDTH and phase).

Test Plan:
- Byte load 0x3001, signed=1, mem_rdata=0x80A5 -> resp_rdata=0xFF80; repeat signed=0 -> 0x0080; one access, mem_address=0x3000.
- Aligned word load 0x3000, mem_rdata=0x1234, mem_resp in first strobe cycle -> resp_valid exactly 3 cycles after accept, resp_rdata=0x1234.
- Unaligned word load 0x3001: ACC1 0x3000 rdata 0xAB12, ACC2 0x3002 rdata 0x77CD -> resp_rdata=0xCDAB, one-cycle strobe gap observed.
- Byte store 0x4001 wdata 0x00EE -> mem_wdata=0xEEEE, mem_byte_enable=2'b10, mem_address=0x4000.
- Unaligned word store 0xFFFF wdata 0xBEEF -> ACC1 addr 0xFFFE wdata 0xEFBE be 2'b10; ACC2 addr 0x0000 wdata 0xEFBE be 2'b01.
- Reset asserted in ACC2 -> strobes low next cycle, req_ready=1, no resp_valid; stray mem_resp afterwards ignored. ALLOW_UNALIGNED=0, word load 0x3001 -> no strobes, resp_err=1 with resp_valid.
